inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 26 ++
 rtl/inst_fetch_if.sv | 36 +++
 rtl/inst_fetch.sv | 133 +++++++++++++
 tb/tb_inst_fetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared CPU constants used by the instruction-fetch stage:
//   ADDR_W / DATA_W  : 32-bit address and instruction widths
//   RESET_PC         : boot vector loaded into the PC and the fetch bundle
//   ST_*             : fetch FSM state encoding
//   word_aligned()   : true when an address is on a 4-byte boundary
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = 32'hbfc00000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_DISCARD = 3'd4;

    function automatic logic word_aligned(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Instruction-memory request/response bus between the fetch stage and memory.
//   inst_req      fetch -> mem   request strobe
//   inst_addr     fetch -> mem   request address
//   inst_addr_ok  mem -> fetch   address accepted this cycle
//   inst_data_ok  mem -> fetch   read data valid this cycle
//   inst_rdata    mem -> fetch   returned instruction word
// Modports: master (fetch stage), slave (memory).
// -----------------------------------------------------------------------------
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch stage: issues one memory request at a time for the address
// held in the PC register, holds the returned word for decode, and drops any
// word whose fetch was overtaken by a redirect (flush).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   pc_i          current PC register output (fetch address)
//   flush         redirect this cycle (PC register loads newpc on this edge)
//   id_allow      decode accepts the held instruction this cycle
//   mem           instruction-memory bus (inst_fetch_if.master)
//   pc_en         PC advance enable, one pulse per accepted request
//   if_valid      fetched bundle valid (only while holding)
//   if_pc/if_inst fetched address and instruction word
//   if_adel       address error: misaligned fetch, if_inst forced to zero
// -----------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush,
    input  logic              id_allow,
    inst_fetch_if.master      mem,
    output logic              pc_en,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_adel
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       aligned;
    logic       ld_pc;     // address accepted: remember which PC is in flight
    logic       ld_inst;   // data returned for a live request
    logic       ld_adel;   // misaligned PC: build an address-error bundle

    assign aligned       = word_aligned(pc_i);
    assign mem.inst_addr = pc_i;
    // Misaligned addresses are never sent to memory.
    assign mem.inst_req  = (state == ST_REQ) && aligned;
    // A coincident flush also raises pc_en; the PC register's clear wins.
    assign pc_en         = mem.inst_req && mem.inst_addr_ok;
    assign if_valid      = (state == ST_HOLD);

    always_comb begin
        state_nxt = state;
        ld_pc     = 1'b0;
        ld_inst   = 1'b0;
        ld_adel   = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (!aligned) begin
                    // With a flush the PC is being replaced, so retry from REQ.
                    if (!flush) begin
                        state_nxt = ST_HOLD;
                        ld_adel   = 1'b1;
                    end
                end else if (mem.inst_addr_ok) begin
                    if (flush) begin
                        // Request is already on the bus; its data must be eaten.
                        state_nxt = ST_DISCARD;
                    end else begin
                        state_nxt = ST_WAIT;
                        ld_pc     = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (mem.inst_data_ok) begin
                    if (flush) begin
                        state_nxt = ST_REQ;
                    end else begin
                        state_nxt = ST_HOLD;
                        ld_inst   = 1'b1;
                    end
                end else if (flush) begin
                    state_nxt = ST_DISCARD;
                end
            end
            ST_HOLD: begin
                if (flush || id_allow) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (mem.inst_data_ok) begin
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Holding register for the bundle presented to decode. It only changes on
    // the load strobes, so it stays stable for the whole HOLD state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_pc   <= RESET_PC;
            if_inst <= '0;
            if_adel <= 1'b0;
        end else if (ld_adel) begin
            if_pc   <= pc_i;
            if_inst <= '0;
            if_adel <= 1'b1;
        end else begin
            if (ld_pc) begin
                if_pc   <= pc_i;
                if_adel <= 1'b0;
            end
            if (ld_inst) begin
                if_inst <= mem.inst_rdata;
                if_adel <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Bench for inst_fetch: models the PC register and instruction memory around
// the fetch stage, predicts delivered instructions at transaction level and
// checks them in an independent monitor.
// -----------------------------------------------------------------------------
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_reg;
    logic        flush = 1'b0;
    logic [31:0] newpc = 32'h0;
    logic        id_allow = 1'b0;
    logic        pc_en;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;

    inst_fetch_if bus();

    inst_fetch dut (
        .clk      (clk),
        .rst      (rst),
        .pc_i     (pc_reg),
        .flush    (flush),
        .id_allow (id_allow),
        .mem      (bus),
        .pc_en    (pc_en),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_adel  (if_adel)
    );

    always #5 clk = ~clk;

    // PC register: clear (flush) has priority over the advance enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        pc_reg <= RESET_PC;
        else if (flush) pc_reg <= newpc;
        else if (pc_en) pc_reg <= pc_reg + 32'd4;
    end

    int    n_chk = 0;
    int    n_err = 0;
    item_t q[$];

    // Transaction-level model state
    bit          out_valid;
    bit          out_killed;
    logic [31:0] out_pc;
    int          lat;
    logic [31:0] exp_next;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One cycle: drive inputs on the falling edge, then update the model.
    // A fetch yields an instruction only if no flush occurs from the cycle its
    // address is accepted through the cycle its data returns.
    task automatic step(input bit f, input logic [31:0] np, input bit ida,
                        input bit aok, input bit dok, input logic [31:0] rd);
        bit    acc;
        item_t it;
        @(negedge clk);
        flush             = f;
        newpc             = np;
        id_allow          = ida;
        bus.inst_addr_ok  = aok;
        bus.inst_data_ok  = dok;
        bus.inst_rdata    = rd;
        #1;
        acc = bus.inst_req && aok;
        if (out_valid) begin
            if (f) out_killed = 1'b1;
            if (dok) begin
                if (!out_killed) begin
                    it.pc   = out_pc;
                    it.inst = rd;
                    it.adel = 1'b0;
                    q.push_back(it);
                end
                out_valid = 1'b0;
            end else if (lat > 0) begin
                lat--;
            end
        end
        if (acc) begin
            chk("req_addr", bus.inst_addr, exp_next);
            out_valid  = 1'b1;
            out_killed = f;
            out_pc     = exp_next;
            lat        = $urandom_range(0, 2);
        end
        if (f)        exp_next = np;
        else if (acc) exp_next = exp_next + 32'd4;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst              = 1'b1;
        flush            = 1'b0;
        id_allow         = 1'b0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        #1;
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_inst_req", 32'(bus.inst_req), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_if_adel", 32'(if_adel), 32'd0);
        chk("rst_if_inst", if_inst, 32'h0);
        chk("rst_if_pc", if_pc, RESET_PC);
        q.delete();
        out_valid = 1'b0;
        exp_next  = RESET_PC;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: each rise of if_valid delivers the next expected instruction;
    // while valid stays high the bundle must not change and no request issues.
    initial begin
        bit    prev;
        bit    have;
        item_t cur;
        prev = 1'b0;
        have = 1'b0;
        cur  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
                have = 1'b0;
                continue;
            end
            if (if_valid) begin
                chk("hold_no_req", 32'(bus.inst_req), 32'd0);
                if (!prev) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_valid: got if_pc=%h if_inst=%h, none expected", if_pc, if_inst);
                        have = 1'b0;
                    end else begin
                        cur  = q.pop_front();
                        have = 1'b1;
                    end
                end
                if (have) begin
                    chk("if_pc", if_pc, cur.pc);
                    chk("if_inst", if_inst, cur.inst);
                    chk("if_adel", 32'(if_adel), 32'(cur.adel));
                end
            end
            prev = if_valid;
        end
    end

    initial begin
        item_t it;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        out_valid  = 1'b0;
        out_killed = 1'b0;
        out_pc     = 32'h0;
        lat        = 0;
        exp_next   = RESET_PC;

        do_reset();

        // Normal fetch
        step(0, 0, 0, 1, 0, 0);
        chk("nf_pc_en", 32'(pc_en), 32'd1);
        chk("nf_addr", bus.inst_addr, 32'hbfc00000);
        step(0, 0, 0, 0, 1, 32'h24080001);
        chk("nf_not_yet_valid", 32'(if_valid), 32'd0);
        step(0, 0, 1, 0, 0, 0);
        chk("nf_valid", 32'(if_valid), 32'd1);
        chk("nf_if_pc", if_pc, 32'hbfc00000);
        chk("nf_if_inst", if_inst, 32'h24080001);

        // Flush while waiting for data
        step(0, 0, 0, 1, 0, 0);
        step(1, 32'hbfc00380, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("fw_discard_no_req", 32'(bus.inst_req), 32'd0);
        chk("fw_no_valid0", 32'(if_valid), 32'd0);
        step(0, 0, 0, 0, 1, 32'hdeadbeef);
        chk("fw_no_valid1", 32'(if_valid), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        chk("fw_req", 32'(bus.inst_req), 32'd1);
        chk("fw_newpc", bus.inst_addr, 32'hbfc00380);
        chk("fw_no_valid2", 32'(if_valid), 32'd0);

        // Flush coincident with address acceptance
        step(1, 32'hbfc00100, 0, 1, 0, 0);
        chk("fa_pc_en", 32'(pc_en), 32'd1);
        step(0, 0, 0, 0, 0, 0);
        chk("fa_discard_no_req", 32'(bus.inst_req), 32'd0);
        step(0, 0, 0, 0, 1, 32'h11111111);
        step(0, 0, 0, 1, 0, 0);
        chk("fa_newpc", bus.inst_addr, 32'hbfc00100);
        step(0, 0, 0, 0, 1, 32'h3c1d0010);

        // Stalled decode, with a stray data_ok that must be ignored
        step(0, 0, 0, 0, 1, 32'hffffffff);
        repeat (4) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("st_released", 32'(if_valid), 32'd0);
        chk("st_req", 32'(bus.inst_req), 32'd1);
        chk("st_next_addr", bus.inst_addr, 32'hbfc00104);

        // Misaligned fetch
        step(1, 32'hbfc00002, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("ma_no_req", 32'(bus.inst_req), 32'd0);
        chk("ma_no_pc_en", 32'(pc_en), 32'd0);
        it.pc   = 32'hbfc00002;
        it.inst = 32'h0;
        it.adel = 1'b1;
        q.push_back(it);
        step(1, 32'hbfc00300, 0, 0, 0, 0);
        chk("ma_valid", 32'(if_valid), 32'd1);
        step(0, 0, 0, 1, 0, 0);
        chk("ma_flushed", 32'(if_valid), 32'd0);

        // Reset while waiting for data
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        chk("rw_req", 32'(bus.inst_req), 32'd1);
        chk("rw_addr", bus.inst_addr, RESET_PC);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit          f;
            logic [31:0] np;
            f  = ($urandom_range(0, 11) == 0);
            np = 32'hbfc00000 | ($urandom & 32'h0000fffc);
            step(f, np, ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
                 (out_valid && lat == 0), $urandom);
        end

        // Drain: no new requests, decode always ready
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 1, 0, (out_valid && lat == 0), $urandom);
        end
        chk("queue_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
